// File: rtl/rbb_writer_pkg.sv
// Shared definitions for the rbb result-batch writer and rbb-side logic.
package rbb_writer_pkg;

   typedef enum logic [1:0] {
      ST_ISSUE  = 2'd0,
      ST_SETTLE = 2'd1,
      ST_DRAIN  = 2'd2
   } rbb_wr_state_e;

   // Lines per batch for a given line-index width.
   function automatic int unsigned num_lines(input int unsigned addr_w);
      return 32'd1 << addr_w;
   endfunction

endpackage

// File: rtl/rbb_outst_ctr.sv
// Outstanding-request up/down counter with full, empty, one and sticky underflow flags.
module rbb_outst_ctr #(
   parameter int unsigned MAX_CNT = 64,
   parameter int unsigned CNT_W   = $clog2(MAX_CNT + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic i_inc,
   input  logic i_dec,
   output logic o_full_c,
   output logic o_empty_c,
   output logic o_one_c,
   output logic o_underflow
);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_uflow;

   // A decrement on an empty counter holds at zero and flags underflow.
   always_comb begin
      w_cnt_nxt = r_cnt;
      w_uflow   = 1'b0;
      if (i_inc && !i_dec) begin
         w_cnt_nxt = r_cnt + CNT_W'(1);
      end else if (!i_inc && i_dec) begin
         if (r_cnt == '0) begin
            w_uflow = 1'b1;
         end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt       <= '0;
         o_underflow <= 1'b0;
      end else begin
         r_cnt <= w_cnt_nxt;
         if (w_uflow) begin
            o_underflow <= 1'b1;
         end
      end
   end

   assign o_full_c  = (r_cnt >= CNT_W'(MAX_CNT));
   assign o_empty_c = (r_cnt == '0);
   assign o_one_c   = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/rbb_writer.sv
// Drains rbb result batches to host memory, one line per write request, and counts completed batches.
module rbb_writer
   import rbb_writer_pkg::*;
#(
   parameter int unsigned RBB_RD_ADDR_WIDTH = 8,
   parameter int unsigned RBB_RD_DATA_WIDTH = 512,
   parameter int unsigned HOST_ADDR_WIDTH   = 32,
   parameter int unsigned MAX_OUTST         = 64,
   parameter int unsigned BATCH_CNT_WIDTH   = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [HOST_ADDR_WIDTH-1:0]   ctl_base_addr,
   input  logic                         ReqValid,
   input  logic [RBB_RD_ADDR_WIDTH-1:0] ReqLineIdx,
   input  logic [RBB_RD_DATA_WIDTH-1:0] RdDout,
   output logic                         ReqAck,
   output logic                         wr_req_valid,
   output logic [HOST_ADDR_WIDTH-1:0]   wr_req_addr,
   output logic [RBB_RD_DATA_WIDTH-1:0] wr_req_data,
   output logic [RBB_RD_ADDR_WIDTH-1:0] wr_req_mdata,
   input  logic                         wr_almost_full,
   input  logic                         wr_rsp_valid,
   output logic                         batch_done,
   output logic [BATCH_CNT_WIDTH-1:0]   batch_cnt,
   output logic                         err_rsp_underflow
);

   localparam int unsigned NUM_LINES = num_lines(RBB_RD_ADDR_WIDTH);
   localparam int unsigned OUTST_W   = $clog2(MAX_OUTST + 1);
   localparam logic [RBB_RD_ADDR_WIDTH-1:0] LAST_IDX = RBB_RD_ADDR_WIDTH'(NUM_LINES - 1);

   rbb_wr_state_e              r_state;
   rbb_wr_state_e              w_state_nxt;
   logic                       r_last;
   logic                       w_fire;
   logic                       w_drain_done;
   logic                       w_full;
   logic                       w_empty;
   logic                       w_one;
   logic [HOST_ADDR_WIDTH-1:0] w_line_off;

   rbb_outst_ctr #(
      .MAX_CNT (MAX_OUTST),
      .CNT_W   (OUTST_W)
   ) u_outst (
      .clk         (clk),
      .reset       (reset),
      .i_inc       (w_fire),
      .i_dec       (wr_rsp_valid),
      .o_full_c    (w_full),
      .o_empty_c   (w_empty),
      .o_one_c     (w_one),
      .o_underflow (err_rsp_underflow)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_ISSUE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Drain completes when the counter is empty after this cycle's responses.
   always_comb begin
      w_state_nxt  = r_state;
      w_fire       = 1'b0;
      w_drain_done = 1'b0;
      case (r_state)
         ST_ISSUE: begin
            if (ReqValid && !wr_almost_full && !w_full && !reset) begin
               w_fire      = 1'b1;
               w_state_nxt = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            w_state_nxt = r_last ? ST_DRAIN : ST_ISSUE;
         end
         ST_DRAIN: begin
            if (w_empty || (w_one && wr_rsp_valid)) begin
               w_drain_done = 1'b1;
               w_state_nxt  = ST_ISSUE;
            end
         end
         default: begin
            w_state_nxt = ST_ISSUE;
         end
      endcase
   end

   assign ReqAck     = w_fire;
   assign w_line_off = HOST_ADDR_WIDTH'({batch_cnt, ReqLineIdx});

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_req_valid <= 1'b0;
         wr_req_addr  <= '0;
         wr_req_data  <= '0;
         wr_req_mdata <= '0;
         r_last       <= 1'b0;
         batch_done   <= 1'b0;
         batch_cnt    <= '0;
      end else begin
         wr_req_valid <= w_fire;
         batch_done   <= w_drain_done;
         if (w_fire) begin
            wr_req_addr  <= ctl_base_addr + w_line_off;
            wr_req_data  <= RdDout;
            wr_req_mdata <= ReqLineIdx;
            r_last       <= (ReqLineIdx == LAST_IDX);
         end
         if (w_drain_done) begin
            batch_cnt <= batch_cnt + BATCH_CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_rbb_writer.sv
// Randomised bench for rbb_writer against a transaction-level model of the batch writer.
module tb_rbb_writer;

   localparam int unsigned AW   = 2;
   localparam int unsigned DW   = 64;
   localparam int unsigned HAW  = 32;
   localparam int unsigned MAXO = 2;
   localparam int unsigned BCW  = 16;
   localparam int unsigned NL   = 1 << AW;
   localparam int          BUDGET = 3000;

   typedef struct packed {
      logic [HAW-1:0] addr;
      logic [DW-1:0]  data;
      logic [AW-1:0]  tag;
   } wr_t;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic [HAW-1:0] ctl_base_addr = '0;
   logic           ReqValid = 1'b0;
   logic [AW-1:0]  ReqLineIdx = '0;
   logic [DW-1:0]  RdDout = '0;
   logic           ReqAck;
   logic           wr_req_valid;
   logic [HAW-1:0] wr_req_addr;
   logic [DW-1:0]  wr_req_data;
   logic [AW-1:0]  wr_req_mdata;
   logic           wr_almost_full = 1'b0;
   logic           wr_rsp_valid = 1'b0;
   logic           batch_done;
   logic [BCW-1:0] batch_cnt;
   logic           err_rsp_underflow;

   rbb_writer #(
      .RBB_RD_ADDR_WIDTH (AW),
      .RBB_RD_DATA_WIDTH (DW),
      .HOST_ADDR_WIDTH   (HAW),
      .MAX_OUTST         (MAXO),
      .BATCH_CNT_WIDTH   (BCW)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .ctl_base_addr     (ctl_base_addr),
      .ReqValid          (ReqValid),
      .ReqLineIdx        (ReqLineIdx),
      .RdDout            (RdDout),
      .ReqAck            (ReqAck),
      .wr_req_valid      (wr_req_valid),
      .wr_req_addr       (wr_req_addr),
      .wr_req_data       (wr_req_data),
      .wr_req_mdata      (wr_req_mdata),
      .wr_almost_full    (wr_almost_full),
      .wr_rsp_valid      (wr_rsp_valid),
      .batch_done        (batch_done),
      .batch_cnt         (batch_cnt),
      .err_rsp_underflow (err_rsp_underflow)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // model state
   wr_t            exp_q[$];
   logic [DW-1:0]  rbb_data [NL];
   int             m_outst, host_pend, m_batch, rbb_idx, drain_age;
   bit             drain_pend, prev_ack, exp_done, m_err;
   // stimulus knobs
   bit             rbb_en, rnd_valid, af_force, force_rsp;
   int             af_pct, rsp_mode, rsp_pct, rel_cnt;
   // DUT event counters
   int             dut_ack_cnt, dut_req_cnt, dut_done_cnt;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic new_batch_data();
      for (int i = 0; i < NL; i++) rbb_data[i] = {$urandom, $urandom};
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_outst = 0; host_pend = 0; m_batch = 0; rbb_idx = 0; drain_age = 0;
      drain_pend = 0; prev_ack = 0; exp_done = 0; m_err = 0;
      new_batch_data();
   endtask

   // One clock: check registered outputs, drive inputs, check ReqAck, advance the model.
   task automatic cycle();
      bit exp_ack, rsp, uflow;
      wr_t e;
      logic [63:0] a;
      @(negedge clk);
      if (exp_done) begin
         drain_pend = 0;
         m_batch++;
      end
      if (wr_req_valid) dut_req_cnt++;
      if (batch_done) dut_done_cnt++;
      chk("batch_done", batch_done, exp_done);
      chk("batch_cnt", batch_cnt, 64'(m_batch % 65536));
      chk("err_rsp_underflow", err_rsp_underflow, m_err);
      chk("wr_req_valid", wr_req_valid, prev_ack);
      if (prev_ack) begin
         if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("wr_req_addr", wr_req_addr, e.addr);
            chk("wr_req_data", wr_req_data, e.data);
            chk("wr_req_mdata", wr_req_mdata, e.tag);
         end
         host_pend++;
      end

      ReqValid       = rbb_en && (!rnd_valid || $urandom_range(3) != 0);
      ReqLineIdx     = AW'(rbb_idx);
      RdDout         = rbb_data[rbb_idx];
      wr_almost_full = af_force || ($urandom_range(99) < af_pct);
      exp_ack = ReqValid && !wr_almost_full && (m_outst < MAXO) && !prev_ack && !drain_pend;
      case (rsp_mode)
         1: begin
            rsp = (host_pend > 0) && (rel_cnt > 0);
            if (rsp) rel_cnt--;
         end
         3: rsp = (host_pend > 0) && exp_ack;
         default: rsp = (host_pend > 0) && ($urandom_range(99) < rsp_pct);
      endcase
      if (force_rsp) rsp = 1;
      wr_rsp_valid = rsp;
      #1;
      if (ReqAck) dut_ack_cnt++;
      chk("ReqAck", ReqAck, exp_ack);

      if (rsp && host_pend > 0) host_pend--;
      uflow = rsp && !exp_ack && (m_outst == 0);
      if (uflow) m_err = 1;
      m_outst = m_outst + int'(exp_ack) - int'(rsp && !uflow);
      exp_done = 0;
      if (exp_ack) begin
         a = 64'(ctl_base_addr) + 64'(m_batch % 65536) * 64'(NL) + 64'(rbb_idx);
         e.addr = a[HAW-1:0];
         e.data = rbb_data[rbb_idx];
         e.tag  = AW'(rbb_idx);
         exp_q.push_back(e);
         if (rbb_idx == NL - 1) begin
            drain_pend = 1;
            drain_age  = 0;
            rbb_idx    = 0;
            new_batch_data();
         end else begin
            rbb_idx++;
         end
      end else if (drain_pend) begin
         drain_age++;
         exp_done = (drain_age >= 2) && (m_outst == 0);
      end
      prev_ack = exp_ack;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("rst_ReqAck", ReqAck, 0);
      chk("rst_wr_req_valid", wr_req_valid, 0);
      chk("rst_wr_req_addr", wr_req_addr, 0);
      chk("rst_wr_req_data", wr_req_data, 0);
      chk("rst_wr_req_mdata", wr_req_mdata, 0);
      chk("rst_batch_done", batch_done, 0);
      chk("rst_batch_cnt", batch_cnt, 0);
      chk("rst_err", err_rsp_underflow, 0);
      ReqValid = 1'b0; wr_rsp_valid = 1'b0; wr_almost_full = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic run_batches(input int tgt);
      int n = 0;
      while (m_batch < tgt && n < BUDGET) begin cycle(); n++; end
      chk("timeout_batches", 64'(m_batch >= tgt), 1);
   endtask

   task automatic run_to_idx(input int idx);
      int n = 0;
      while (rbb_idx != idx && n < BUDGET) begin cycle(); n++; end
      chk("timeout_idx", 64'(rbb_idx == idx), 1);
   endtask

   // Complete the current batch with prompt responses and leave the rbb idle.
   task automatic finish_batch();
      int n = 0;
      int tgt = m_batch + 1;
      rsp_mode = 0; rsp_pct = 100; rbb_en = 1;
      while (!drain_pend && n < BUDGET) begin cycle(); n++; end
      rbb_en = 0;
      run_batches(tgt);
   endtask

   initial begin
      rbb_en = 0; rnd_valid = 0; af_force = 0; force_rsp = 0;
      af_pct = 0; rsp_mode = 0; rsp_pct = 100; rel_cnt = 0;
      dut_ack_cnt = 0; dut_req_cnt = 0; dut_done_cnt = 0;
      ctl_base_addr = 32'h1000;
      do_reset();

      // first and second batch, no backpressure, immediate responses
      rbb_en = 1; dut_done_cnt = 0;
      run_batches(1);
      chk("b1_done_cnt", dut_done_cnt, 1);
      chk("b1_batch_cnt", batch_cnt, 1);
      run_batches(2);
      chk("b2_batch_cnt", batch_cnt, 2);

      // almost_full held 10 cycles mid-batch
      run_to_idx(2);
      af_force = 1; dut_ack_cnt = 0;
      cycle();
      dut_req_cnt = 0;
      repeat (9) cycle();
      chk("af_hold_acks", dut_ack_cnt, 0);
      chk("af_hold_reqs", dut_req_cnt, 0);
      af_force = 0;
      finish_batch();

      // outstanding limit with responses withheld
      rsp_mode = 1; rel_cnt = 0; rbb_en = 1; dut_req_cnt = 0;
      repeat (12) cycle();
      chk("limit_reqs", dut_req_cnt, MAXO);
      rel_cnt = 1; dut_req_cnt = 0;
      repeat (8) cycle();
      chk("release_reqs", dut_req_cnt, 1);
      finish_batch();

      // responses coincident with fire, last response withheld in drain
      rsp_mode = 3; rbb_en = 1;
      begin
         int n = 0;
         while (!drain_pend && n < BUDGET) begin cycle(); n++; end
      end
      rbb_en = 0; rsp_mode = 1; rel_cnt = 0; dut_done_cnt = 0;
      repeat (8) cycle();
      chk("drain_wait_done", dut_done_cnt, 0);
      finish_batch();
      chk("coinc_done_cnt", dut_done_cnt, 1);

      // response with nothing outstanding
      chk("pre_err", err_rsp_underflow, 0);
      force_rsp = 1;
      cycle();
      force_rsp = 0;
      cycle();
      chk("err_sticky", err_rsp_underflow, 1);
      rsp_mode = 1; rel_cnt = 0; rbb_en = 1; dut_req_cnt = 0;
      repeat (10) cycle();
      chk("post_uflow_limit_reqs", dut_req_cnt, MAXO);
      finish_batch();

      // randomised traffic across the address wrap
      ctl_base_addr = 32'hFFFF_FFF6;
      rnd_valid = 1; af_pct = 20; rsp_mode = 0; rsp_pct = 40; rbb_en = 1;
      run_batches(m_batch + 4);

      // reset mid-batch, then a clean batch afterwards
      run_to_idx(2);
      do_reset();
      rnd_valid = 0; af_pct = 0; rsp_pct = 100; rbb_en = 1;
      ctl_base_addr = 32'h1000;
      run_batches(1);
      chk("post_reset_batch_cnt", batch_cnt, 1);
      chk("post_reset_err", err_rsp_underflow, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
